// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight writers after decode, selects E-stage
// forwarding sources, and raises decode stalls for load-use and mult/div conflicts.
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int NSTG     = 4,
  parameter int LOAD_RDY = 3,
  parameter int MDIV_CYC = 33,
  parameter int FW       = $clog2(NSTG)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [AW-1:0] RS_D,
  input  logic [AW-1:0] RT_D,
  input  logic [AW-1:0] DST_D,
  input  logic          WR_D,
  input  logic          LOAD_D,
  input  logic          MDIV_D,
  input  logic          MFHL_D,
  input  logic          FLUSH_E,
  output logic [FW-1:0] FWD_A,
  output logic [FW-1:0] FWD_B,
  output logic          STALL_D,
  output logic          MDIV_BUSY
);

  localparam int CW = $clog2(MDIV_CYC + 1);

  logic [NSTG-1:0] valid_reg;
  logic [NSTG-1:0] wr_reg;
  logic [NSTG-1:0] load_reg;
  logic [AW-1:0]   dst_reg [NSTG];
  logic            mdiv_e_reg;
  logic [AW-1:0]   rs_e_reg;
  logic [AW-1:0]   rt_e_reg;

  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic            busy_reg;

  logic            accept;
  logic            mdiv_launch;
  logic            load_use_stall;
  logic            mdiv_stall;
  logic [NSTG-1:1] cand_a;
  logic [NSTG-1:1] cand_b;
  logic [NSTG-1:0] lu_hit;

  // A decode instruction enters E only when neither held nor killed.
  assign accept = !STALL_D && !FLUSH_E;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_reg  <= '0;
      wr_reg     <= '0;
      load_reg   <= '0;
      for (int s = 0; s < NSTG; s++) begin
        dst_reg[s] <= '0;
      end
      mdiv_e_reg <= 1'b0;
      rs_e_reg   <= '0;
      rt_e_reg   <= '0;
    end else begin
      valid_reg[0] <= accept;
      wr_reg[0]    <= accept && WR_D;
      load_reg[0]  <= accept && LOAD_D;
      dst_reg[0]   <= accept ? DST_D : '0;
      mdiv_e_reg   <= accept && MDIV_D;
      rs_e_reg     <= RS_D;
      rt_e_reg     <= RT_D;
      for (int s = 1; s < NSTG; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        wr_reg[s]    <= wr_reg[s-1];
        load_reg[s]  <= load_reg[s-1];
        dst_reg[s]   <= dst_reg[s-1];
      end
      // A flushed E instruction still advances, but as a dead record.
      if (FLUSH_E) begin
        valid_reg[1] <= 1'b0;
      end
    end
  end

  genvar gi;

  generate
    for (gi = 1; gi < NSTG; gi++) begin : g_fwd
      logic fwd_ok;
      assign fwd_ok     = valid_reg[gi] && wr_reg[gi] && (dst_reg[gi] != '0) &&
                          (!load_reg[gi] || (gi >= LOAD_RDY));
      assign cand_a[gi] = fwd_ok && (dst_reg[gi] == rs_e_reg);
      assign cand_b[gi] = fwd_ok && (dst_reg[gi] == rt_e_reg);
    end

    // Loads whose data will not be forwardable by the time the consumer reaches E.
    for (gi = 0; gi < NSTG; gi++) begin : g_load_use
      assign lu_hit[gi] = valid_reg[gi] && load_reg[gi] && (dst_reg[gi] != '0) &&
                          ((gi + 1) < LOAD_RDY) &&
                          ((dst_reg[gi] == RS_D) || (dst_reg[gi] == RT_D));
    end
  endgenerate

  // Scan from the oldest stage down so the nearest producer overrides.
  always_comb begin
    FWD_A = '0;
    FWD_B = '0;
    for (int s = NSTG - 1; s >= 1; s--) begin
      if (cand_a[s]) FWD_A = FW'(s);
      if (cand_b[s]) FWD_B = FW'(s);
    end
    if (!valid_reg[0]) begin
      FWD_A = '0;
      FWD_B = '0;
    end
  end

  assign mdiv_launch = valid_reg[0] && mdiv_e_reg && !FLUSH_E;

  always_comb begin
    cnt_next = cnt_reg;
    if (mdiv_launch) begin
      cnt_next = CW'(MDIV_CYC);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign MDIV_BUSY      = busy_reg;
  assign load_use_stall = |lu_hit;
  assign mdiv_stall     = (MFHL_D || MDIV_D) && (busy_reg || (valid_reg[0] && mdiv_e_reg));
  assign STALL_D        = load_use_stall || mdiv_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus a randomized run
// against an instruction-history model of the forwarding and stall rules.
module tb_hazard_scoreboard;

  localparam int AW       = 5;
  localparam int NSTG     = 4;
  localparam int LOAD_RDY = 3;
  localparam int MDIV_CYC = 33;
  localparam int FW       = 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [AW-1:0] RS_D = '0;
  logic [AW-1:0] RT_D = '0;
  logic [AW-1:0] DST_D = '0;
  logic          WR_D = 1'b0;
  logic          LOAD_D = 1'b0;
  logic          MDIV_D = 1'b0;
  logic          MFHL_D = 1'b0;
  logic          FLUSH_E = 1'b0;
  logic [FW-1:0] FWD_A;
  logic [FW-1:0] FWD_B;
  logic          STALL_D;
  logic          MDIV_BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            enter;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    bit            wr;
    bit            ld;
    bit            md;
    bit            killed;
  } instr_t;

  instr_t hist[$];

  hazard_scoreboard #(
    .AW(AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY), .MDIV_CYC(MDIV_CYC), .FW(FW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .RS_D(RS_D), .RT_D(RT_D), .DST_D(DST_D),
    .WR_D(WR_D), .LOAD_D(LOAD_D), .MDIV_D(MDIV_D), .MFHL_D(MFHL_D),
    .FLUSH_E(FLUSH_E),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_D(STALL_D), .MDIV_BUSY(MDIV_BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
    $fatal(1);
  end

  task automatic set_dec(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dst, input logic wr, input logic ld,
                         input logic md, input logic mf);
    RS_D = rs; RT_D = rt; DST_D = dst;
    WR_D = wr; LOAD_D = ld; MDIV_D = md; MFHL_D = mf;
  endtask

  task automatic idle();
    set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    FLUSH_E = 1'b0;
  endtask

  task automatic tick();
    $display("t=%0t rs=%0d rt=%0d dst=%0d wr=%0b ld=%0b md=%0b mf=%0b fl=%0b | fwd_a=%0d fwd_b=%0d stall=%0b busy=%0b",
             $time, RS_D, RT_D, DST_D, WR_D, LOAD_D, MDIV_D, MFHL_D, FLUSH_E,
             FWD_A, FWD_B, STALL_D, MDIV_BUSY);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    idle();
    #1;
    n_cmp++; if (FWD_A !== 2'd0) begin n_bad++; $display("FAIL reset_fwd_a got=%0d exp=0", FWD_A); end
    n_cmp++; if (FWD_B !== 2'd0) begin n_bad++; $display("FAIL reset_fwd_b got=%0d exp=0", FWD_B); end
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%0b exp=0", STALL_D); end
    n_cmp++; if (MDIV_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", MDIV_BUSY); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b0 || MDIV_BUSY !== 1'b0)
      begin n_bad++; $display("FAIL post_release_idle got stall=%0b busy=%0b exp 0/0", STALL_D, MDIV_BUSY); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_dec(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_dec(5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL alu_no_stall got=%0b exp=0", STALL_D); end
    tick();
    set_dec(5'd3, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd1) begin n_bad++; $display("FAIL alu_fwd_a_m1 got=%0d exp=1", FWD_A); end
    n_cmp++; if (FWD_B !== 2'd0) begin n_bad++; $display("FAIL alu_fwd_b_none got=%0d exp=0", FWD_B); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd1) begin n_bad++; $display("FAIL alu_nearest_a got=%0d exp=1", FWD_A); end
    n_cmp++; if (FWD_B !== 2'd1) begin n_bad++; $display("FAIL alu_nearest_b got=%0d exp=1", FWD_B); end
    set_dec(5'd9, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    FLUSH_E = 1'b1;
    tick();
    FLUSH_E = 1'b0;
    @(negedge CLK);
    // E now holds a bubble whose rs/rt still name live producers.
    n_cmp++; if (FWD_A !== 2'd0 || FWD_B !== 2'd0)
      begin n_bad++; $display("FAIL bubble_fwd got a=%0d b=%0d exp 0/0", FWD_A, FWD_B); end
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    set_dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_dec(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (!STALL_D) break;
      n++;
      tick();
    end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL load_use_stall_cycles got=%0d exp=2", n); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd3) begin n_bad++; $display("FAIL load_use_fwd_a got=%0d exp=3", FWD_A); end
    n_cmp++; if (FWD_B !== 2'd0) begin n_bad++; $display("FAIL load_use_fwd_b got=%0d exp=0", FWD_B); end
  endtask

  task automatic test_zero();
    do_reset();
    set_dec(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL zero_stall_e got=%0b exp=0", STALL_D); end
    tick();
    set_dec(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL zero_stall_m1 got=%0b exp=0", STALL_D); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd0 || FWD_B !== 2'd0)
      begin n_bad++; $display("FAIL zero_fwd got a=%0d b=%0d exp 0/0", FWD_A, FWD_B); end
  endtask

  task automatic test_mdiv();
    int n;
    int nb;
    do_reset();
    set_dec(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_dec(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    n = 0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!STALL_D) break;
      if (MDIV_BUSY) nb++;
      n++;
      tick();
    end
    n_cmp++; if (n !== MDIV_CYC + 1) begin n_bad++; $display("FAIL mdiv_stall_cycles got=%0d exp=%0d", n, MDIV_CYC + 1); end
    n_cmp++; if (nb !== MDIV_CYC) begin n_bad++; $display("FAIL mdiv_busy_cycles got=%0d exp=%0d", nb, MDIV_CYC); end
    n_cmp++; if (MDIV_BUSY !== 1'b0) begin n_bad++; $display("FAIL mdiv_busy_at_release got=%0b exp=0", MDIV_BUSY); end
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_dec(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_dec(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    FLUSH_E = 1'b1;
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b1) begin n_bad++; $display("FAIL flush_stall_overlap got=%0b exp=1", STALL_D); end
    tick();
    FLUSH_E = 1'b0;
    set_dec(5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    n_cmp++; if (MDIV_BUSY !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%0b exp=0", MDIV_BUSY); end
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL flush_no_stall got=%0b exp=0", STALL_D); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd0 || FWD_B !== 2'd0)
      begin n_bad++; $display("FAIL flush_fwd got a=%0d b=%0d exp 0/0", FWD_A, FWD_B); end
    n_cmp++; if (MDIV_BUSY !== 1'b0) begin n_bad++; $display("FAIL flush_busy_later got=%0b exp=0", MDIV_BUSY); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_dec(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    repeat (15) tick();
    set_dec(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_dec(5'd4, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    // Counter now sits at 17 with live records in E and M1.
    set_dec(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd1 || FWD_B !== 2'd1 || STALL_D !== 1'b1 || MDIV_BUSY !== 1'b1)
      begin n_bad++; $display("FAIL pre_reset got a=%0d b=%0d stall=%0b busy=%0b exp 1/1/1/1",
                              FWD_A, FWD_B, STALL_D, MDIV_BUSY); end
    #2;
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (FWD_A !== 2'd0 || FWD_B !== 2'd0)
      begin n_bad++; $display("FAIL async_reset_fwd got a=%0d b=%0d exp 0/0", FWD_A, FWD_B); end
    n_cmp++; if (STALL_D !== 1'b0 || MDIV_BUSY !== 1'b0)
      begin n_bad++; $display("FAIL async_reset_stall got stall=%0b busy=%0b exp 0/0", STALL_D, MDIV_BUSY); end
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    set_dec(5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    n_cmp++; if (STALL_D !== 1'b0) begin n_bad++; $display("FAIL after_reset_stall got=%0b exp=0", STALL_D); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (FWD_A !== 2'd0 || FWD_B !== 2'd0 || MDIV_BUSY !== 1'b0)
      begin n_bad++; $display("FAIL after_reset_first got a=%0d b=%0d busy=%0b exp 0/0/0",
                              FWD_A, FWD_B, MDIV_BUSY); end
  endtask

  function automatic bit fwd_cand(instr_t r, int s);
    return !r.killed && r.wr && (r.dst != '0) && (!r.ld || s >= LOAD_RDY);
  endfunction

  task automatic test_random(input int ncyc);
    int     cyc;
    int     busy_until;
    int     e_idx;
    int     exp_a;
    int     exp_b;
    int     st;
    bit     exp_busy;
    bit     exp_stall;
    bit     lu;
    bit     ms;
    instr_t ni;
    do_reset();
    hist.delete();
    cyc = 0;
    busy_until = 0;
    for (int k = 0; k < ncyc; k++) begin
      set_dec(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0));
      FLUSH_E = ($urandom_range(0, 11) == 0);

      // The instruction in E is the one that entered on the most recent edge.
      e_idx = -1;
      foreach (hist[i]) if (hist[i].enter == cyc) e_idx = i;
      exp_a = 0;
      exp_b = 0;
      if (e_idx >= 0) begin
        for (int s = 1; s < NSTG; s++) begin
          foreach (hist[i]) begin
            if (hist[i].enter == cyc - s && fwd_cand(hist[i], s)) begin
              if (exp_a == 0 && hist[i].dst == hist[e_idx].rs) exp_a = s;
              if (exp_b == 0 && hist[i].dst == hist[e_idx].rt) exp_b = s;
            end
          end
        end
      end
      exp_busy = (cyc < busy_until);
      lu = 1'b0;
      foreach (hist[i]) begin
        st = cyc - hist[i].enter;
        if (st >= 0 && st < NSTG && !hist[i].killed && hist[i].ld && hist[i].dst != '0 &&
            st + 1 < LOAD_RDY && (hist[i].dst == RS_D || hist[i].dst == RT_D)) lu = 1'b1;
      end
      ms = (MFHL_D || MDIV_D) && (exp_busy || (e_idx >= 0 && hist[e_idx].md));
      exp_stall = lu || ms;

      @(negedge CLK);
      n_cmp++; if (FWD_A !== FW'(exp_a)) begin n_bad++; $display("FAIL rnd_fwd_a cyc=%0d got=%0d exp=%0d", cyc, FWD_A, exp_a); end
      n_cmp++; if (FWD_B !== FW'(exp_b)) begin n_bad++; $display("FAIL rnd_fwd_b cyc=%0d got=%0d exp=%0d", cyc, FWD_B, exp_b); end
      n_cmp++; if (STALL_D !== exp_stall) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, STALL_D, exp_stall); end
      n_cmp++; if (MDIV_BUSY !== exp_busy) begin n_bad++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, MDIV_BUSY, exp_busy); end
      $display("rnd cyc=%0d rs=%0d rt=%0d dst=%0d wr=%0b ld=%0b md=%0b mf=%0b fl=%0b | fwd_a=%0d fwd_b=%0d stall=%0b busy=%0b",
               cyc, RS_D, RT_D, DST_D, WR_D, LOAD_D, MDIV_D, MFHL_D, FLUSH_E,
               FWD_A, FWD_B, STALL_D, MDIV_BUSY);

      @(posedge CLK);
      if (e_idx >= 0 && hist[e_idx].md && !FLUSH_E) busy_until = cyc + 1 + MDIV_CYC;
      if (e_idx >= 0 && FLUSH_E) hist[e_idx].killed = 1'b1;
      if (!exp_stall && !FLUSH_E) begin
        ni.enter = cyc + 1;
        ni.rs = RS_D; ni.rt = RT_D; ni.dst = DST_D;
        ni.wr = WR_D; ni.ld = LOAD_D; ni.md = MDIV_D; ni.killed = 1'b0;
        hist.push_back(ni);
      end
      cyc++;
      while (hist.size() > 0 && cyc - hist[0].enter >= NSTG) void'(hist.pop_front());
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero();
    test_mdiv();
    test_flush();
    test_reset_mid();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
- REQ-001: The block SHALL have parameter AW, default 5, meaning register-index width (2**AW architectural registers).
- REQ-002: The block SHALL have parameter NSTG, default 4, meaning tracked stages after decode (index 0=E, 1..NSTG-1=M1..WB).
- REQ-003: The block SHALL have parameter LOAD_RDY, default 3, meaning the lowest stage index at which load data is forwardable.
- REQ-004: The block SHALL have parameter MDIV_CYC, default 33, meaning mult/div busy cycles after launch.
- REQ-005: The block SHALL have parameter FW, default $clog2(NSTG), meaning forward-select width.
- REQ-006: Port list, in order:
  - CLK  in  1  clock, rising edge.
  - RESET_N  in  1  asynchronous, active-low reset.
  - RS_D, RT_D  in  AW  source registers of the decode instruction.
  - DST_D  in  AW  destination register of the decode instruction.
  - WR_D  in  1  decode instruction writes the register file.
  - LOAD_D  in  1  decode instruction is a load.
  - MDIV_D  in  1  decode instruction launches mult/div.
  - MFHL_D  in  1  decode instruction reads HI/LO.
  - FLUSH_E  in  1  kill the instruction in E.
  - FWD_A, FWD_B  out  FW  E-stage operand source: 0=regfile, s=stage s.
  - STALL_D  out  1  hold F/D this cycle.
  - MDIV_BUSY  out  1  mult/div counter nonzero.

Function
- REQ-007: The block SHALL keep NSTG records {valid, dst, wr, load, mdiv}, plus E-stage rs/rt registers.
- REQ-008: Every rising edge, records in stages 0..NSTG-2 SHALL shift to s+1, and the stage NSTG-1 record SHALL be discarded.
- REQ-009: On an edge with STALL_D=0 and FLUSH_E=0, stage 0 SHALL load the decode fields with valid=1.
- REQ-010: On an edge with STALL_D=1 or FLUSH_E=1, stage 0 SHALL load a bubble (valid=0).
- REQ-011: On an edge with FLUSH_E=1, the current stage-0 record SHALL move to stage 1 with valid=0.
- REQ-012: A record SHALL be a forwarding candidate when valid=1, wr=1, dst!=0, and either load=0 or its stage index >= LOAD_RDY.
- REQ-013: FWD_A SHALL be the lowest stage index s in 1..NSTG-1 whose candidate dst equals E rs, and 0 if there is none.
- REQ-014: FWD_B SHALL follow the same rule as REQ-013 using E rt.
- REQ-015: FWD_A and FWD_B SHALL be 0 whenever stage 0 is invalid.
- REQ-016: Register 0 SHALL never match, for forwarding or for stall.
- REQ-017: Load-use stall SHALL be asserted when a valid load record at stage s, with s+1 < LOAD_RDY and dst!=0, has dst equal to RS_D or RT_D.
- REQ-018: The mult/div counter SHALL reset to 0.
- REQ-019: The counter SHALL load MDIV_CYC on an edge where a valid, unflushed mdiv record leaves stage 0.
- REQ-020: Otherwise the counter SHALL decrement by 1 while nonzero and saturate at 0.
- REQ-021: MDIV_BUSY SHALL equal (counter != 0), registered.
- REQ-022: Mult/div stall SHALL be asserted when MFHL_D=1 or MDIV_D=1, and either MDIV_BUSY=1 or stage 0 holds a valid mdiv record.
- REQ-023: STALL_D SHALL be combinational and equal to (load-use stall OR mult/div stall).
- REQ-024: If FLUSH_E=1 and STALL_D=1 on the same edge, the flush rules (REQ-010, REQ-011) SHALL apply.
- REQ-025: If FLUSH_E=1 and STALL_D=1 on the same edge, a flushed mdiv record SHALL NOT start the counter.
- REQ-026: Stall and flush SHALL NOT freeze any stage >= 1; later stages always advance.
- REQ-027: If counter reload (REQ-019) and decrement (REQ-020) coincide, the reload SHALL win.

Reset
- REQ-028: While RESET_N=0, all record valid bits SHALL be 0.
- REQ-029: While RESET_N=0, dst, rs and rt SHALL be 0.
- REQ-030: While RESET_N=0, the counter SHALL be 0.
- REQ-031: While RESET_N=0, FWD_A=0, FWD_B=0, STALL_D=0 and MDIV_BUSY=0.
- REQ-032: Reset SHALL take effect asynchronously, mid-operation included, and release SHALL be synchronous to CLK.

Verification
- REQ-033: The bench SHALL cover ALU chain: add r3; then rs=r3 next cycle -> FWD_A=1; one cycle later with another add r3 in M1 -> FWD_A=1, nearest record wins.
- REQ-034: The bench SHALL cover load-use: lw r5 accepted, then RS_D=r5 -> STALL_D=1 for 2 cycles (defaults); at E, FWD_A=3.
- REQ-035: The bench SHALL cover $zero: lw r0 followed by RT_D=0 -> STALL_D=0 and FWD_B=0.
- REQ-036: The bench SHALL cover mult/div: mult accepted, then MFHL_D=1 -> STALL_D=1 while in E plus 33 busy cycles; STALL_D=0 on the cycle MDIV_BUSY falls.
- REQ-037: The bench SHALL cover flush: mult in E with FLUSH_E=1 -> MDIV_BUSY stays 0; a later dependent read gets FWD=0.
- REQ-038: The bench SHALL cover reset: RESET_N low while counter=17 and records valid -> all outputs 0 immediately; after release the first instruction gets FWD=0.
